load_store_unit: RTL and testbench

//  Memory-stage load/store unit of the 5-stage pipelined RV32I core.
//  - Decodes the ALU-computed address against the memory map.
//  - Writes byte/half/word stores into data memory and output peripherals.
//  - Returns sign/zero-extended load data one cycle later, aligned with the

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_dmem.sv | 18 +
 rtl/load_store_unit.sv | 123 ++++++++++++
 tb/tb_load_store_unit.sv | 111 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: memory-map bases, funct3 encodings, region codes and byte-lane merge helper
package lsu_pkg;
    localparam logic [19:0] DMEM_BASE   = 20'h00000;
    localparam logic [19:0] LEDR_BASE   = 20'h10000;
    localparam logic [19:0] LEDG_BASE   = 20'h10001;
    localparam logic [19:0] HEX_LO_BASE = 20'h10002;
    localparam logic [19:0] HEX_HI_BASE = 20'h10003;
    localparam logic [19:0] LCD_BASE    = 20'h10004;
    localparam logic [19:0] SW_BASE     = 20'h10010;
    localparam logic [19:0] KEY_BASE    = 20'h10011;

    typedef enum logic [2:0] {LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5} mem_funct3_e;

    typedef enum logic [3:0] {
        R_NONE, R_DMEM, R_LEDR, R_LEDG, R_HEX_LO, R_HEX_HI, R_LCD, R_SW, R_KEY
    } region_e;

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] be);
        for (int k = 0; k < 4; k++)
            if (be[k]) old[8*k +: 8] = wdata[8*k +: 8];
        return old;
    endfunction
endpackage

// File: rtl/lsu_dmem.sv
// lsu_dmem: byte-enabled synchronous single-port data RAM, read-old-data on a write edge
module lsu_dmem #(
    parameter int DMEM_AW = 13
) (
    input  logic               i_clk,
    input  logic [3:0]         i_be,
    input  logic [DMEM_AW-3:0] i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata
);
    logic [31:0] mem [0:2**(DMEM_AW-2)-1];

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++)
            if (i_be[k]) mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        o_rdata <= mem[i_addr];
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU with address decode, DMEM, output peripherals
// and a one-cycle load path aligned with writeback.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DMEM_AW = 13
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_key,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd
);
    logic [19:0] page;
    region_e     region, region_q;
    mem_funct3_e f3_q;
    logic [1:0]  off_q;
    logic [3:0]  be;
    logic [31:0] wdata, io_rd, io_q, dmem_rdata, word;
    logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d, hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d, lcd_q, lcd_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        wr;

    assign page = i_lsu_addr[31:12];
    assign wr   = i_insn_vld & i_lsu_wren;

    always_comb begin
        region = i_lsu_addr[31:DMEM_AW] == DMEM_BASE[19:DMEM_AW-12] ? R_DMEM :
                 page == LEDR_BASE   ? R_LEDR   : page == LEDG_BASE   ? R_LEDG   :
                 page == HEX_LO_BASE ? R_HEX_LO : page == HEX_HI_BASE ? R_HEX_HI :
                 page == LCD_BASE    ? R_LCD    : page == SW_BASE     ? R_SW     :
                 page == KEY_BASE    ? R_KEY    : R_NONE;
        // Misaligned halves/words fall back to the enclosing aligned lanes
        be    = i_funct3[1:0] == 2'b00 ? 4'b0001 << i_lsu_addr[1:0] :
                i_funct3[1:0] == 2'b01 ? (i_lsu_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata = i_funct3[1:0] == 2'b00 ? {4{i_st_data[7:0]}} :
                i_funct3[1:0] == 2'b01 ? {2{i_st_data[15:0]}} : i_st_data;
    end

    always_comb begin
        ledr_d   = wr && region == R_LEDR ? merge_be(ledr_q, wdata, be) : ledr_q;
        ledg_d   = wr && region == R_LEDG ? merge_be(ledg_q, wdata, be) : ledg_q;
        hex_lo_d = wr && region == R_HEX_LO ? merge_be(hex_lo_q, wdata, be) & 32'h7F7F7F7F : hex_lo_q;
        hex_hi_d = wr && region == R_HEX_HI ? merge_be(hex_hi_q, wdata, be) & 32'h7F7F7F7F : hex_hi_q;
        lcd_d    = wr && region == R_LCD ? merge_be(lcd_q, wdata, be) : lcd_q;
        io_rd    = region == R_LEDR   ? ledr_q   : region == R_LEDG   ? ledg_q   :
                   region == R_HEX_LO ? hex_lo_q : region == R_HEX_HI ? hex_hi_q :
                   region == R_LCD    ? lcd_q    : region == R_SW     ? i_io_sw  :
                   region == R_KEY    ? {28'b0, i_io_key} : 32'b0;
    end

    lsu_dmem #(.DMEM_AW(DMEM_AW)) u_dmem (
        .i_clk   (i_clk),
        .i_be    (wr && region == R_DMEM ? be : 4'b0),
        .i_addr  (i_lsu_addr[DMEM_AW-1:2]),
        .i_wdata (wdata),
        .o_rdata (dmem_rdata)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q   <= '0;
            ledg_q   <= '0;
            hex_lo_q <= '0;
            hex_hi_q <= '0;
            lcd_q    <= '0;
            region_q <= R_NONE;
            f3_q     <= LW;
            off_q    <= '0;
            io_q     <= '0;
        end else begin
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            hex_lo_q <= hex_lo_d;
            hex_hi_q <= hex_hi_d;
            lcd_q    <= lcd_d;
            region_q <= region;
            f3_q     <= mem_funct3_e'(i_funct3);
            off_q    <= i_lsu_addr[1:0];
            io_q     <= io_rd;
        end
    end

    // Reset parks region_q on R_NONE so the load result is forced to zero
    always_comb begin
        word      = region_q == R_DMEM ? dmem_rdata : io_q;
        ld_byte   = word[{off_q, 3'b000} +: 8];
        ld_half   = off_q[1] ? word[31:16] : word[15:0];
        o_ld_data = f3_q == LB  ? {{24{ld_byte[7]}}, ld_byte} :
                    f3_q == LH  ? {{16{ld_half[15]}}, ld_half} :
                    f3_q == LBU ? {24'b0, ld_byte} :
                    f3_q == LHU ? {16'b0, ld_half} : word;
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_lo_q[6:0];
    assign o_io_hex1 = hex_lo_q[14:8];
    assign o_io_hex2 = hex_lo_q[22:16];
    assign o_io_hex3 = hex_lo_q[30:24];
    assign o_io_hex4 = hex_hi_q[6:0];
    assign o_io_hex5 = hex_hi_q[14:8];
    assign o_io_hex6 = hex_hi_q[22:16];
    assign o_io_hex7 = hex_hi_q[30:24];
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed store/load vectors with hand-computed expectations
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n, insn_vld, wren;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data, io_sw, ld_data, ledr, ledg, lcd, rd;
    logic [3:0]  io_key;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_insn_vld(insn_vld), .i_lsu_wren(wren),
        .i_funct3(funct3), .i_lsu_addr(addr), .i_st_data(st_data), .i_io_sw(io_sw),
        .i_io_key(io_key), .o_ld_data(ld_data), .o_io_ledr(ledr), .o_io_ledg(ledg),
        .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
        .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
        .o_io_lcd(lcd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic v);
        @(negedge clk);
        insn_vld = v; wren = 1'b1; addr = a; st_data = d; funct3 = f;
        @(negedge clk);
        insn_vld = 1'b0; wren = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] f, output logic [31:0] d);
        @(negedge clk);
        insn_vld = 1'b1; wren = 1'b0; addr = a; funct3 = f;
        @(negedge clk);
        insn_vld = 1'b0;
        d = ld_data;
    endtask

    initial begin
        rst_n = 1'b0; insn_vld = 1'b0; wren = 1'b0; funct3 = 3'd2;
        addr = '0; st_data = '0; io_sw = '0; io_key = '0;
        repeat (2) @(negedge clk);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_ledr", ledr, 32'h0);
        rst_n = 1'b1;

        st(32'h1000_0000, 32'hFFFF_FFFF, 3'd2, 1'b1);
        chk("ledr_write", ledr, 32'hFFFF_FFFF);
        st(32'h1000_1000, 32'h0000_00C3, 3'd2, 1'b1);
        st(32'h1000_4002, 32'h0000_005A, 3'd0, 1'b1);
        chk("lcd_sb_lane2", lcd, 32'h005A_0000);
        st(32'h1000_3000, 32'hFFFF_FFFF, 3'd2, 1'b1);
        chk("hex4_bit7_drop", {25'b0, hex4}, 32'h7F);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_ledr", ledr, 32'h0);
        chk("async_rst_ledg", ledg, 32'h0);
        chk("async_rst_lcd", lcd, 32'h0);
        chk("async_rst_hex4", {25'b0, hex4}, 32'h0);
        chk("async_rst_ld", ld_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ld(32'h1000_0000, 3'd2, rd); chk("ledr_after_rst", rd, 32'h0);

        st(32'h100, 32'h1234_5678, 3'd2, 1'b1);
        st(32'h101, 32'h0000_00AB, 3'd0, 1'b1);
        ld(32'h100, 3'd2, rd); chk("lw_100", rd, 32'h1234_AB78);
        ld(32'h101, 3'd0, rd); chk("lb_101", rd, 32'hFFFF_FFAB);
        ld(32'h101, 3'd4, rd); chk("lbu_101", rd, 32'h0000_00AB);
        ld(32'h102, 3'd1, rd); chk("lh_102", rd, 32'h0000_1234);

        st(32'h40, 32'hDEAD_BEEF, 3'd2, 1'b1);
        ld(32'h40, 3'd2, rd); chk("b2b_lw_40", rd, 32'hDEAD_BEEF);

        st(32'h1000_2000, 32'h7F3F_064F, 3'd2, 1'b1);
        chk("hex0", {25'b0, hex0}, 32'h4F);
        chk("hex1", {25'b0, hex1}, 32'h06);
        chk("hex2", {25'b0, hex2}, 32'h3F);
        chk("hex3", {25'b0, hex3}, 32'h7F);
        ld(32'h1000_2000, 3'd2, rd); chk("hex_lo_readback", rd, 32'h7F3F_064F);
        io_sw = 32'hA5; io_key = 4'b1010;
        ld(32'h1001_0000, 3'd2, rd); chk("lw_sw", rd, 32'h0000_00A5);
        ld(32'h1001_1000, 3'd2, rd); chk("lw_key", rd, 32'h0000_000A);

        st(32'h40, 32'h0000_0000, 3'd2, 1'b0);
        ld(32'h40, 3'd2, rd); chk("gated_store", rd, 32'hDEAD_BEEF);
        st(32'h1000_0000, 32'h0000_55AA, 3'd2, 1'b1);
        st(32'h2000_0000, 32'hFFFF_FFFF, 3'd2, 1'b1);
        chk("unmapped_ledr", ledr, 32'h0000_55AA);
        chk("unmapped_hex0", {25'b0, hex0}, 32'h4F);
        ld(32'h2000_0000, 3'd2, rd); chk("unmapped_lw", rd, 32'h0);
        st(32'h1001_0000, 32'h0000_0000, 3'd2, 1'b1);
        ld(32'h1001_0000, 3'd2, rd); chk("ro_sw_store", rd, 32'h0000_00A5);

        st(32'h200, 32'h1122_3344, 3'd2, 1'b1);
        st(32'h203, 32'h0000_BEEF, 3'd1, 1'b1);
        ld(32'h200, 3'd2, rd); chk("misaligned_sh", rd, 32'hBEEF_3344);
        ld(32'h203, 3'd1, rd); chk("misaligned_lh", rd, 32'hFFFF_BEEF);
        ld(32'h202, 3'd5, rd); chk("lhu_202", rd, 32'h0000_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
